// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes ALU requests, drives the ALU one cycle and returns a registered result.
// Optional ALU_SEQ_OVF_EN adds rsp_ovf, the signed overflow of the funct add/sub passes.
module alu_op_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
`ifdef ALU_SEQ_OVF_EN
  output logic             rsp_ovf,
`endif
  output logic             rsp_illegal
);
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] dec_ctrl;
  logic dec_illegal, dec_slt, illegal_q, slt_q, sub_ovf, slt_bit;
  always_comb begin
    dec_ctrl = 4'b0000;
    dec_illegal = 1'b0;
    dec_slt = 1'b0;
    case (req_aluop)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b10:
        case (req_funct)
          6'b100000, 6'b100001: dec_ctrl = 4'b0010;
          6'b100010, 6'b100011: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b100111: dec_ctrl = 4'b1100;
          6'b101010: begin
            dec_ctrl = 4'b0110;
            dec_slt = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      default: dec_illegal = 1'b1;
    endcase
  end
  always_comb begin
    state_nx = state == IDLE ? (req_valid ? EXEC : IDLE) :
               state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
  end
  // SLT runs as a SUB; a signed overflow flips the sign bit, so correct it here
  assign sub_ovf = (alu_a[M] != alu_b[M]) && (alu_result[M] != alu_a[M]);
  assign slt_bit = alu_neg ^ sub_ovf;
`ifdef ALU_SEQ_OVF_EN
  logic sadd_q, ssub_q, add_ovf;
  assign add_ovf = (alu_a[M] == alu_b[M]) && (alu_result[M] != alu_a[M]);
  always_ff @(posedge clk)
    if (!rst_n) begin
      sadd_q <= 1'b0;
      ssub_q <= 1'b0;
      rsp_ovf <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        sadd_q <= req_aluop == 2'b10 && req_funct == 6'b100000;
        ssub_q <= req_aluop == 2'b10 && req_funct == 6'b100010;
      end
      if (state == EXEC) rsp_ovf <= (sadd_q && add_ovf) || (ssub_q && sub_ovf);
    end
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= 4'b0000;
      illegal_q <= 1'b0;
      slt_q <= 1'b0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        alu_a <= req_a;
        alu_b <= req_b;
        alu_ctrl <= dec_ctrl;
        illegal_q <= dec_illegal;
        slt_q <= dec_slt;
      end
      if (state == EXEC) begin
        rsp_result <= illegal_q ? '0 : slt_q ? {{M{1'b0}}, slt_bit} : alu_result;
        rsp_zero <= illegal_q ? 1'b1 : slt_q ? ~slt_bit : alu_zero;
        rsp_illegal <= illegal_q;
      end
    end
endmodule
